// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // Most-negative 32-bit dividend; paired with a -1 divisor it forms the signed overflow case.
    localparam logic [DIV_WIDTH-1:0] DIV_OVF_A = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    // DIV and REM treat their operands as two's complement.
    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    // DIV and DIVU return the quotient; REM and REMU return the remainder.
    function automatic logic op_is_quot(input div_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, then conditionally subtract.
module div_unit_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // Partial remainder stays below the divisor, so after the shift it needs one extra bit.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        ge      = shifted >= {1'b0, divisor_i};
        rem_o   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       div_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hold,
    input  logic             abort,
    output logic             div_stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] res_q, res_d;
    div_op_t          op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    div_op_t          op_in;
    logic             in_signed;
    logic             b_zero;
    logic             ovf;
    logic             special;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             last_step;
    logic [WIDTH-1:0] fixed_res;

    assign op_in     = div_op_t'(div_ctrl);
    assign in_signed = op_is_signed(op_in);
    assign b_zero    = (op_b == '0);
    assign ovf       = in_signed && (op_a == MIN_NEG) && (op_b == '1);
    assign special   = b_zero || ovf;
    // MIN_NEG negates to itself, which read as unsigned is exactly its magnitude.
    assign abs_a     = (in_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b     = (in_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    assign last_step = (cnt_q == CNT_W'(1));

    div_unit_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (rem_nx),
        .quo_o    (quo_nx)
    );

    // Sign correction is applied to the final iteration's outputs so the result is ready on entering DONE.
    assign fixed_res = op_is_quot(op_q) ? (neg_quo_q ? -quo_nx : quo_nx)
                                        : (neg_rem_q ? -rem_nx : rem_nx);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = special ? DONE : BUSY;
                BUSY:    if (last_step) state_d = DONE;
                DONE:    if (!hold) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; result is forced to zero outside DONE.
    always_comb begin
        busy         = (state_q != IDLE);
        result_valid = (state_q == DONE);
        result       = (state_q == DONE) ? res_q : '0;
        div_stall    = ((state_q == IDLE) && start) || (state_q == BUSY);
    end

    // Datapath next-state: operand capture, early-out results and the per-cycle iteration.
    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (!abort) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (b_zero) begin
                            res_d = op_is_quot(op_in) ? '1 : op_a;
                        end else if (ovf) begin
                            res_d = (op_in == DIV) ? MIN_NEG : '0;
                        end else begin
                            quo_d     = abs_a;
                            dvs_d     = abs_b;
                            rem_d     = '0;
                            cnt_d     = CNT_W'(WIDTH);
                            op_d      = op_in;
                            neg_quo_d = in_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            neg_rem_d = in_signed && op_a[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    quo_d = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (last_step) res_d = fixed_res;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            op_q      <= DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Upstream only issues start while the unit is idle.
    a_start_idle: assert property (@(posedge clk) disable iff (rst) !(start && (state_q != IDLE)));

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: table of operations plus hold, abort and reset sequences.
module tb_div_unit;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  div_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hold;
    logic        abort;
    logic        div_stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int tests;
    int fails;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    div_unit #(
        .WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .div_ctrl    (div_ctrl),
        .op_a        (op_a),
        .op_b        (op_b),
        .hold        (hold),
        .abort       (abort),
        .div_stall   (div_stall),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge with the unit idle again.
    task automatic do_div(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        int   cyc;
        logic stall_ok;
        start    = 1'b1;
        div_ctrl = ctrl;
        op_a     = a;
        op_b     = b;
        #1;
        check({name, "_stall_c0"}, {31'd0, div_stall}, 32'd1);
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        stall_ok = 1'b1;
        while (!result_valid && cyc < 40) begin
            if (div_stall !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({name, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'(lat));
        check({name, "_result"}, result, exp);
        check({name, "_stall_done"}, {31'd0, div_stall}, 32'd0);
        @(negedge clk);
        check({name, "_idle_after"}, {30'd0, busy, result_valid}, 32'd0);
    endtask

    initial begin
        int   cyc;
        logic seen;

        vecs[0]  = '{2'b00, 32'd100,       32'd7,         32'd14,        33, "div_100_7"};
        vecs[1]  = '{2'b10, 32'd100,       32'd7,         32'd2,         33, "rem_100_7"};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_m7_2"};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2"};
        vecs[4]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, "rem_7_m2"};
        vecs[5]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, "divu_max_1"};
        vecs[6]  = '{2'b11, 32'hFFFF_FFFF, 32'h10,        32'hF,         33, "remu_max_16"};
        vecs[7]  = '{2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        33, "div_m100_m7"};
        vecs[8]  = '{2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, "rem_m100_m7"};
        vecs[9]  = '{2'b00, DIV_OVF_A,     32'd2,         32'hC000_0000, 33, "div_minneg_2"};
        vecs[10] = '{2'b01, 32'd3,         32'd5,         32'd0,         33, "divu_3_5"};
        vecs[11] = '{2'b11, 32'd3,         32'd5,         32'd3,         33, "remu_3_5"};
        vecs[12] = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "div_5_0"};
        vecs[13] = '{2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_5_0"};
        vecs[14] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  "rem_m5_0"};
        vecs[15] = '{2'b11, 32'd5,         32'd0,         32'd5,         1,  "remu_5_0"};
        vecs[16] = '{2'b00, DIV_OVF_A,     32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf"};
        vecs[17] = '{2'b10, DIV_OVF_A,     32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf"};
        vecs[18] = '{2'b01, DIV_OVF_A,     32'hFFFF_FFFF, 32'd0,         33, "divu_noovf"};

        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        abort    = 1'b0;
        div_ctrl = 2'b00;
        op_a     = '0;
        op_b     = '0;

        #1;
        check("reset_busy",  {31'd0, busy},         32'd0);
        check("reset_stall", {31'd0, div_stall},    32'd0);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result", result,               32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            do_div(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
        end

        // hold through DONE: result stays put for 3+1 cycles, then a back-to-back start.
        start    = 1'b1;
        div_ctrl = 2'b00;
        op_a     = 32'd100;
        op_b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!result_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("hold_latency", 32'(cyc), 32'd33);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid",  {31'd0, result_valid}, 32'd1);
            check("hold_result", result,                32'd14);
            if (i == 3) hold = 1'b0;
            @(negedge clk);
        end
        check("hold_release", {30'd0, busy, result_valid}, 32'd0);
        do_div(2'b10, 32'd100, 32'd7, 32'd2, 33, "b2b_rem");

        // abort mid-divide: back to IDLE on the next edge, no result ever appears.
        start    = 1'b1;
        div_ctrl = 2'b00;
        op_a     = 32'd100;
        op_b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_stall_c10", {31'd0, div_stall}, 32'd1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_idle", {29'd0, busy, div_stall, result_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check("abort_no_result", {31'd0, seen}, 32'd0);

        // asynchronous reset mid-divide clears outputs without waiting for a clock edge.
        start    = 1'b1;
        div_ctrl = 2'b01;
        op_a     = 32'd100;
        op_b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("prerst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy",   {31'd0, busy},         32'd0);
        check("rst_stall",  {31'd0, div_stall},    32'd0);
        check("rst_valid",  {31'd0, result_valid}, 32'd0);
        check("rst_result", result,                32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_div(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, "post_rst_div");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the EXECUTE stage. It accepts the single-cycle start pulse that the decode/execute pipeline register issues when a divide enters EX. It holds the pipeline via div_stall until the quotient or remainder is ready, then presents the result for one accepted cycle. Divide-by-zero and signed overflow resolve early per the RISC-V specification.

Parameters:
WIDTH, 32, operand/result width
CNT_W, $clog2(WIDTH)+1, iteration counter width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse: divide instruction entered EX; operands valid this cycle
div_ctrl  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start
op_a  input  WIDTH  dividend (forwarded rs1); sampled with start
op_b  input  WIDTH  divisor (forwarded rs2); sampled with start
hold  input  1  pipeline frozen (cache stall); result must not be consumed
abort  input  1  synchronous kill of an in-flight divide
div_stall  output  1  freeze IF/ID/EX; combinational
busy  output  1  state != IDLE
result_valid  output  1  result consumable this cycle
result  output  WIDTH  quotient or remainder, sign-corrected

Behaviour:
- Reset: state IDLE; counter, quotient, remainder, divisor, flags cleared. Outputs: div_stall 0, busy 0, result_valid 0, result 0.
- States: IDLE, BUSY, DONE.
- IDLE, start=1, normal case:
  - latch |op_a| into quotient register, |op_b| into divisor, remainder=0, count=WIDTH.
  - latch op (div_ctrl), neg_q = signed op & (a[MSB]^b[MSB]), neg_r = signed op & a[MSB].
  - go to BUSY.
- IDLE, start=1, op_b==0: latch result_reg = (quotient op ? all-ones : op_a); go to DONE.
- IDLE, start=1, signed overflow (op_a==0x8000_0000, op_b==all-ones, DIV/REM): latch result_reg = (DIV ? 0x8000_0000 : 0); go to DONE.
- Unsigned ops never take the overflow path.
- BUSY step, one per edge:
  - r' = {rem[WIDTH-1:0], quo[MSB]}; quo <<= 1.
  - if r' >= divisor (WIDTH+1-bit compare): rem = r' - divisor, quo[0] = 1; else rem = r'.
  - count decrements; after the step with count==1, go to DONE.
  - on entering DONE from BUSY, latch the sign-corrected value into result_reg: quotient op -> (neg_q ? -quo : quo); remainder op -> (neg_r ? -rem : rem).
- DONE:
  - result_valid=1, result=result_reg, div_stall=0.
  - hold=0: next edge -> IDLE.
  - hold=1: stay in DONE; result stable.
- div_stall = (state==IDLE & start) | (state==BUSY). Never asserted in DONE.
- Latency, start cycle = cycle 0:
  - normal: div_stall high cycles 0..WIDTH, result_valid at cycle WIDTH+1 (33 for WIDTH=32).
  - special cases: div_stall high cycle 0 only, result_valid at cycle 1.
- result is 0 whenever result_valid=0.
- start while not IDLE is ignored; flagged by a simulation assertion. The upstream register cannot legally issue it.
- abort in any state: next edge -> IDLE. Abort has priority over start and over the BUSY step. div_stall still follows the formula in the abort cycle.
- rst mid-operation: immediate return to reset values; no residual result.
- Arithmetic: magnitudes computed as two's complement negate of MSB-set operands. |0x8000_0000| = 0x8000_0000 unsigned, which is correct.

Decomposition:
- div_pkg: div_op_t enum (DIV, DIVU, REM, REMU = 2'b00..2'b11), div_state_t enum (IDLE, BUSY, DONE), DIV_OVF_A constant (0x8000_0000).
- Sub-module div_step: combinational single iteration; inputs rem, quo, divisor; outputs next rem and next quo. Enables a later radix-4 variant by instantiating two.

Test Plan:
- DIV 100/7 start at cycle 0 -> div_stall 1 for cycles 0..32; result_valid at 33 with result 14. REM same operands -> 2.
- Signed signs: DIV -7/2 -> 0xFFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF (-1); REM 7/-2 -> 1. DIVU 0xFFFF_FFFF/1 -> 0xFFFF_FFFF; REMU 0xFFFF_FFFF/0x10 -> 0xF.
- Divide by zero: DIV 5/0 -> 0xFFFF_FFFF; DIVU 5/0 -> 0xFFFF_FFFF; REM -5/0 -> 0xFFFF_FFFB. Each: stall only cycle 0, result_valid at cycle 1.
- Overflow: DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM same -> 0; DIVU same -> 0x0000_0000 after the full 33-cycle path.
- hold=1 during DONE for 3 cycles -> result_valid and result stable for 3+1 cycles, then IDLE. A back-to-back start one cycle after DONE -> second result correct.
- abort at cycle 10 of a divide -> IDLE next edge, div_stall 0, no result_valid. Async rst at cycle 20 -> all outputs 0 immediately. A new start afterwards completes correctly.
